// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDUOp values, FSM states,
// and the busy-counter width (wide enough for cycle counts up to 31).
// Imported by mdu and by anything that drives MDUOp symbolically.
package mdu_pkg;

  // Busy counter width; 5 bits covers the legal 1..31 cycle range.
  localparam int CNT_W = 5;

  // MDUOp encodings as presented on the MDUOp port.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_t;

  // Controller states; busy is simply "in RUN".
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// MIPS-style HI/LO multiply/divide unit with a fixed-latency busy window.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES; mthi/mtlo write at the start edge.
// Backpressure: busy high while running; start during busy is ignored (controller stalls).
// Optional divider: define MDU_DIV_EN to build div/divu; otherwise they behave as no-ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Reject cycle counts the counter cannot represent (0 would never finish).
  if (MULT_CYCLES < 1 || MULT_CYCLES > 31) begin : g_bad_mult_cycles
    $error("mdu: MULT_CYCLES out of range 1..31");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 31) begin : g_bad_div_cycles
    $error("mdu: DIV_CYCLES out of range 1..31");
  end

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_op_t          op;
  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      hi_tmp, lo_tmp;
  logic             accept_mul;
  logic             load_hilo;
  logic             wr_hi, wr_lo;
  logic [63:0]      prod_s, prod_u;

  assign op   = mdu_op_t'(MDUOp);
  assign busy = (state == ST_RUN);

  // Full 64-bit products; sign-extending first makes the low 64 bits of the
  // multiply the exact signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

`ifdef MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  logic        accept_div;
  logic        div_by_zero;
  logic [31:0] quo, rem;

  assign div_by_zero = (B == 32'b0);

  // Quotient/remainder; the one signed overflow case is pinned explicitly so
  // it never depends on how a tool treats INT_MIN / -1.
  always_comb begin
    quo = '0;
    rem = '0;
    if (!div_by_zero) begin
      if (op == MDU_DIV) begin
        if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          quo = 32'h8000_0000;
          rem = 32'h0;
        end else begin
          quo = $signed(A) / $signed(B);
          rem = $signed(A) % $signed(B);
        end
      end else begin
        quo = A / B;
        rem = A % B;
      end
    end
  end
`endif

  // Next-state and control decode: accept work only in IDLE, count down in RUN.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept_mul = 1'b0;
    load_hilo  = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
`ifdef MDU_DIV_EN
    accept_div = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              accept_mul = 1'b1;
              cnt_nxt    = MULT_CNT;
              state_nxt  = ST_RUN;
            end
`ifdef MDU_DIV_EN
            MDU_DIV, MDU_DIVU: begin
              accept_div = 1'b1;
              cnt_nxt    = DIV_CNT;
              state_nxt  = ST_RUN;
            end
`endif
            MDU_MTHI: wr_hi = 1'b1;
            MDU_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          load_hilo = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and busy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Result staging and architectural HI/LO. The staged result only reaches
  // HI/LO on the final RUN edge, so an aborting reset discards it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_tmp <= '0;
      lo_tmp <= '0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      if (accept_mul) begin
        {hi_tmp, lo_tmp} <= (op == MDU_MULT) ? prod_s : prod_u;
      end
`ifdef MDU_DIV_EN
      if (accept_div) begin
        // Divide by zero stages the current HI/LO, which cannot change while
        // busy, so completion rewrites them unchanged.
        if (div_by_zero) begin
          hi_tmp <= HI;
          lo_tmp <= LO;
        end else begin
          hi_tmp <= rem;
          lo_tmp <= quo;
        end
      end
`endif
      if (load_hilo) begin
        HI <= hi_tmp;
        LO <= lo_tmp;
      end else begin
        if (wr_hi) HI <= A;
        if (wr_lo) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized traffic against
// a cycle-level HI/LO model built from plain arithmetic.
// Respects MDU_DIV_EN the same way the design does.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural HI/LO, cycles left busy, pending result.
  logic [31:0] m_hi, m_lo;
  int          m_left;
  logic        m_pend_ok;
  logic [63:0] m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_left = 0; m_pend_ok = 1'b0; m_pend = '0;
  endtask

  // What one clock edge does, expressed in terms of the instruction set.
  task automatic model_edge(input logic s, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int     sa, sb;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend_ok) {m_hi, m_lo} = m_pend;
    end else if (s) begin
      case (op)
        3'd1: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          m_pend = sp; m_pend_ok = 1'b1; m_left = MC;
        end
        3'd2: begin
          m_pend = {32'b0, a} * {32'b0, b}; m_pend_ok = 1'b1; m_left = MC;
        end
`ifdef MDU_DIV_EN
        3'd3: begin
          sa = a; sb = b;
          m_left = DC;
          m_pend_ok = (b != 0);
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) m_pend = {32'h0, 32'h8000_0000};
          else if (b != 0) m_pend = {32'(sa % sb), 32'(sa / sb)};
        end
        3'd4: begin
          m_left = DC;
          m_pend_ok = (b != 0);
          if (b != 0) m_pend = {a % b, a / b};
        end
`endif
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle, advance model and DUT by an edge, compare after the edge.
  task automatic step(input logic s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    start = s; MDUOp = op; A = a; B = b;
    model_edge(s, op, a, b);
    @(posedge clk); #1;
    check("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    start = 1'b0; MDUOp = 3'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom);
  endtask

  // Issue an op and run until the model says it is done (bounded).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    step(1'b1, op, a, b);
    guard = 0;
    while (m_left > 0 && guard < 40) begin
      idle(1);
      guard++;
    end
    check("run_bound", guard, (guard < 40) ? guard : 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  int busy_seen;

  initial begin
    start = 0; MDUOp = 0; A = 0; B = 0;
    reset = 1'b1;
    model_reset();
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Start on the very first edge after reset; count busy cycles.
    step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
    busy_seen = busy ? 1 : 0;
    for (int i = 0; i < MC; i++) begin
      idle(1);
      if (busy) busy_seen++;
    end
    check("mult_busy_cycles", busy_seen, MC);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
`ifdef MDU_DIV_EN
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
`else
    check("nodiv_hi", HI, 32'hFFFF_FFFE);
    check("nodiv_lo", LO, 32'h0000_0001);
`endif

    step(1'b1, 3'd5, 32'h55, 32'h0);
    step(1'b1, 3'd6, 32'h55, 32'h0);
    issue(3'd4, 32'd7, 32'd0);
    idle(1);
    check("divz_hi", HI, 32'h55);
    check("divz_lo", LO, 32'h55);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd3, 32'd8, 32'd2);

    // mtlo in idle: visible next cycle, never busy.
    step(1'b1, 3'd6, 32'h1234, 32'h0);
    check("mtlo_lo", LO, 32'h1234);
    check("mtlo_busy", {31'b0, busy}, 32'd0);

    // mthi during busy cycle 3 of a mult is ignored.
    step(1'b1, 3'd1, 32'd3, 32'd5);
    idle(2);
    step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0);
    idle(MC);
    check("mthi_ign_hi", HI, 32'h0);
    check("mthi_ign_lo", LO, 32'd15);

    // start with none/reserved does nothing.
    step(1'b1, 3'd0, 32'h1111, 32'h2222);
    step(1'b1, 3'd7, 32'h3333, 32'h4444);
    check("nop_lo", LO, 32'd15);

    // Reset in the middle of a mult discards it.
    step(1'b1, 3'd1, 32'd3, 32'd4);
    idle(1);
    reset = 1'b1;
    #2;
    model_reset();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    issue(3'd1, 32'd2, 32'd2);
    check("post_rst_lo", LO, 32'd4);
    check("post_rst_hi", HI, 32'd0);

    // Randomized traffic, including starts while busy.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), pick(), pick());
    end
    idle(DC + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
